// File: rtl/ga_ctrl_pkg.sv
// ga_ctrl_pkg: shared state encoding and termination codes for the GA generation controller
package ga_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;
  localparam logic [1:0] TERM_NONE   = 2'd0;
  localparam logic [1:0] TERM_LIMIT  = 2'd1;
  localparam logic [1:0] TERM_TARGET = 2'd2;
  localparam logic [1:0] TERM_STAG   = 2'd3;
endpackage

// File: rtl/ga_best_tracker.sv
// ga_best_tracker: best-of-run register with saturating stagnation counter and look-ahead stag_hit
module ga_best_tracker
  import ga_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH       = 19,
  parameter int FIT_WIDTH        = 32,
  parameter int STAGNATION_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  sample,
  input  logic [DATA_WIDTH-1:0] chrom,
  input  logic [FIT_WIDTH-1:0]  fit,
  output logic [DATA_WIDTH-1:0] best_chrom,
  output logic [FIT_WIDTH-1:0]  best_fit,
  output logic                  stag_hit
);
  localparam int SW = STAGNATION_LIMIT > 0 ? $clog2(STAGNATION_LIMIT + 1) : 1;
  localparam logic [SW-1:0] SL = SW'(STAGNATION_LIMIT);
  logic          best_valid;
  logic          improve;
  logic [SW-1:0] stag_cnt;
  logic [SW-1:0] stag_nxt;
  always_comb begin
    improve  = !best_valid || fit > best_fit;
    stag_nxt = improve ? '0 : stag_cnt == SL ? stag_cnt : stag_cnt + SW'(1);
    stag_hit = STAGNATION_LIMIT != 0 && stag_nxt == SL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      best_valid <= 1'b0;
      best_chrom <= '0;
      best_fit   <= '0;
      stag_cnt   <= '0;
    end else if (clear) begin
      best_valid <= 1'b0;
      stag_cnt   <= '0;
    end else if (sample) begin
      if (improve) begin
        best_valid <= 1'b1;
        best_chrom <= chrom;
        best_fit   <= fit;
      end
      stag_cnt <= stag_nxt;
    end
  end
endmodule

// File: rtl/ga_generation_controller.sv
// ga_generation_controller: restartable GA sequencer issuing progress pulses and terminating on target, limit or stagnation
module ga_generation_controller
  import ga_ctrl_pkg::*;
#(
  parameter int NUM_STAGES       = 4,
  parameter int GENERATION_COUNT = 16,
  parameter int DATA_WIDTH       = 19,
  parameter int FIT_WIDTH        = 32,
  parameter int STAGNATION_LIMIT = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [NUM_STAGES-1:0]                 stage_done,
  input  logic [DATA_WIDTH-1:0]                 best_found_reg,
  input  logic [FIT_WIDTH-1:0]                  best_found_fitness,
  input  logic                                  target_en,
  input  logic [FIT_WIDTH-1:0]                  target_fitness,
  output logic                                  progress_pipeline,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0]                            term_reason,
  output logic [$clog2(GENERATION_COUNT+1)-1:0] gen_count,
  output logic [DATA_WIDTH-1:0]                 best_chrom,
  output logic [FIT_WIDTH-1:0]                  best_fit
);
  localparam int GW = $clog2(GENERATION_COUNT + 1);
  localparam int PW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(NUM_STAGES - 1);
  localparam logic [GW-1:0] G_MAX  = GW'(GENERATION_COUNT);
  state_t        state;
  logic [PW-1:0] pulse_cnt;
  logic          launch;
  logic          restart;
  logic          target_hit;
  logic          limit_hit;
  logic          stag_hit;
  always_comb begin
    launch     = state == RUN && &stage_done && !progress_pipeline;
    restart    = start && (state == IDLE || state == DONE);
    target_hit = target_en && best_found_fitness >= target_fitness;
    limit_hit  = gen_count == G_MAX;
  end
  ga_best_tracker #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIT_WIDTH(FIT_WIDTH),
    .STAGNATION_LIMIT(STAGNATION_LIMIT)
  ) u_tracker (
    .clk(clk),
    .rst(rst),
    .clear(restart),
    .sample(state == EVAL),
    .chrom(best_found_reg),
    .fit(best_found_fitness),
    .best_chrom(best_chrom),
    .best_fit(best_fit),
    .stag_hit(stag_hit)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      progress_pipeline <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      term_reason       <= TERM_NONE;
      gen_count         <= '0;
      pulse_cnt         <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state       <= RUN;
          busy        <= 1'b1;
          done        <= 1'b0;
          term_reason <= TERM_NONE;
          gen_count   <= '0;
          pulse_cnt   <= '0;
        end
        RUN: begin
          progress_pipeline <= launch;
          if (launch) begin
            pulse_cnt <= pulse_cnt == P_LAST ? '0 : pulse_cnt + PW'(1);
            if (pulse_cnt == P_LAST) begin
              gen_count <= gen_count + GW'(1);
              state     <= EVAL;
            end
          end
        end
        EVAL: begin
          progress_pipeline <= 1'b0;
          if (target_hit || limit_hit || stag_hit) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            term_reason <= target_hit ? TERM_TARGET : limit_hit ? TERM_LIMIT : TERM_STAG;
          end else begin
            state <= RUN;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ga_generation_controller.sv
// tb_ga_generation_controller: randomized self-checking bench against a generation-level reference model
module tb_ga_generation_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  stage_done;
  logic [18:0] best_found_reg;
  logic [31:0] best_found_fitness;
  logic        target_en;
  logic [31:0] target_fitness;
  logic        prog0, busy0, done0, prog3, busy3, done3;
  logic [1:0]  term0, term3;
  logic [4:0]  gen0, gen3;
  logic [18:0] bc0, bc3;
  logic [31:0] bf0, bf3;
  logic [31:0] fit_seq [16];
  logic [18:0] chrom_seq [16];
  int checks = 0;
  int errors = 0;
  int viol = 0;
  logic sd_q = 1'b0, rst_q = 1'b1;
  logic p0_q = 1'b0, b0_q = 1'b0, p3_q = 1'b0, b3_q = 1'b0;
  always #5 clk = ~clk;
  ga_generation_controller #(
    .NUM_STAGES(4), .GENERATION_COUNT(16), .DATA_WIDTH(19), .FIT_WIDTH(32), .STAGNATION_LIMIT(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stage_done(stage_done),
    .best_found_reg(best_found_reg), .best_found_fitness(best_found_fitness),
    .target_en(target_en), .target_fitness(target_fitness),
    .progress_pipeline(prog0), .busy(busy0), .done(done0), .term_reason(term0),
    .gen_count(gen0), .best_chrom(bc0), .best_fit(bf0)
  );
  ga_generation_controller #(
    .NUM_STAGES(4), .GENERATION_COUNT(16), .DATA_WIDTH(19), .FIT_WIDTH(32), .STAGNATION_LIMIT(3)
  ) dut_stag (
    .clk(clk), .rst(rst), .start(start), .stage_done(stage_done),
    .best_found_reg(best_found_reg), .best_found_fitness(best_found_fitness),
    .target_en(target_en), .target_fitness(target_fitness),
    .progress_pipeline(prog3), .busy(busy3), .done(done3), .term_reason(term3),
    .gen_count(gen3), .best_chrom(bc3), .best_fit(bf3)
  );
  always @(posedge clk) begin
    sd_q  <= &stage_done;
    rst_q <= rst;
  end
  always @(negedge clk) begin
    if (!rst_q)
      viol <= viol + int'(prog0 && (!sd_q || p0_q || !busy0)) + int'(b0_q && !p0_q && sd_q && !prog0)
                   + int'(prog3 && (!sd_q || p3_q || !busy3)) + int'(b3_q && !p3_q && sd_q && !prog3);
    p0_q <= prog0;
    b0_q <= busy0;
    p3_q <= prog3;
    b3_q <= busy3;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic model(input int lim, output int eg, output int er, output logic [31:0] bf, output logic [18:0] bc);
    int  stag = 0;
    bit  valid = 0;
    bf = 0;
    bc = 0;
    eg = 0;
    er = 0;
    for (int g = 1; g <= 16; g++) begin
      if (!valid || fit_seq[g-1] > bf) begin
        valid = 1;
        bf    = fit_seq[g-1];
        bc    = chrom_seq[g-1];
        stag  = 0;
      end else if (stag < lim) begin
        stag++;
      end
      eg = g;
      if (target_en && fit_seq[g-1] >= target_fitness) begin er = 2; return; end
      if (g == 16) begin er = 1; return; end
      if (lim != 0 && stag == lim) begin er = 3; return; end
    end
  endtask
  task automatic do_run(input int stall_pct, input int abort_at);
    int          e0g, e0r, e3g, e3r, pc0, pc3, idx;
    logic [31:0] e0f, e3f;
    logic [18:0] e0c, e3c;
    model(0, e0g, e0r, e0f, e0c);
    model(3, e3g, e3r, e3f, e3c);
    best_found_fitness = fit_seq[0];
    best_found_reg     = chrom_seq[0];
    stage_done         = 4'hf;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_gen", gen0, 0);
    check("start_term", term0, 0);
    check("start_busy", busy0, 1);
    check("start_done", done0, 0);
    pc0 = 0;
    pc3 = 0;
    for (int cyc = 0; cyc < 3000 && !(done0 && done3); cyc++) begin
      stage_done = ($urandom_range(99) < stall_pct) ? 4'($urandom) : 4'hf;
      @(negedge clk);
      pc0 += int'(prog0);
      pc3 += int'(prog3);
      if (!prog0) begin
        idx = pc0 / 4 > 15 ? 15 : pc0 / 4;
        best_found_fitness = fit_seq[idx];
        best_found_reg     = chrom_seq[idx];
      end
      if (abort_at > 0 && pc0 >= abort_at) break;
    end
    if (abort_at > 0) begin
      check("pre_abort_gen", 64'(gen0 > 0), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_prog", prog0, 0);
      check("abort_busy", busy0, 0);
      check("abort_done", done0, 0);
      check("abort_term", term0, 0);
      check("abort_gen", gen0, 0);
      check("abort_bf", bf0, 0);
      check("abort_bc", bc0, 0);
      check("abort_prog_s", prog3, 0);
      @(negedge clk);
      check("post_abort_prog", prog0, 0);
      check("post_abort_busy", busy0, 0);
      check("protocol", viol, 0);
      return;
    end
    check("finished", 64'(done0 && done3), 1);
    check("busy_end", busy0, 0);
    check("gen", gen0, 64'(e0g));
    check("term", term0, 64'(e0r));
    check("best_fit", bf0, e0f);
    check("best_chrom", bc0, e0c);
    check("pulses", pc0, 64'(4 * e0g));
    check("gen_s", gen3, 64'(e3g));
    check("term_s", term3, 64'(e3r));
    check("best_fit_s", bf3, e3f);
    check("best_chrom_s", bc3, e3c);
    check("pulses_s", pc3, 64'(4 * e3g));
    check("protocol", viol, 0);
  endtask
  task automatic fill(input int kind);
    for (int g = 0; g < 16; g++) begin
      chrom_seq[g] = 19'($urandom);
      fit_seq[g]   = kind == 0 ? 32'd5 : kind == 1 ? 32'(g + 1) : kind == 2 ? 32'(10 * (g + 1)) : 32'($urandom_range(6));
    end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    stage_done = 4'h0;
    best_found_reg = '0;
    best_found_fitness = '0;
    target_en = 1'b0;
    target_fitness = '0;
    repeat (3) @(negedge clk);
    check("rst_prog", prog0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_term", term0, 0);
    check("rst_gen", gen0, 0);
    check("rst_bf", bf0, 0);
    rst = 1'b0;
    @(negedge clk);
    fill(0);
    do_run(0, 0);
    fill(1);
    do_run(40, 0);
    fill(2);
    target_en = 1'b1;
    target_fitness = 32'd100;
    do_run(20, 0);
    fill(1);
    target_fitness = 32'd16;
    do_run(0, 0);
    fill(1);
    target_en = 1'b0;
    do_run(10, 18);
    for (int r = 0; r < 6; r++) begin
      fill(3);
      target_en = 1'($urandom);
      target_fitness = 32'($urandom_range(3, 8));
      do_run(30, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ga_generation_controller.md
Name: ga_generation_controller

Overview:
- Top-level sequencer for the Genetic Algorithm Processor; replaces the free-running, simulation-only generation control with a synthesizable, restartable controller.
- Waits until every pipeline stage (selection, crossover/mutation, fitness, replacement, ...) reports done, then issues a one-cycle progress_pipeline pulse.
- Counts pulses into generations, tracks the best chromosome seen, and terminates on generation limit, target fitness, or stagnation, reporting a status code instead of halting simulation.

Parameters:
- NUM_STAGES, 4, number of stage-done inputs; also the number of progress pulses per generation.
- GENERATION_COUNT, 16, maximum generations per run (>=1).
- DATA_WIDTH, 19, chromosome width.
- FIT_WIDTH, 32, unsigned fixed-point fitness width; higher is better.
- STAGNATION_LIMIT, 8, generations without strict improvement before stopping; 0 disables the check.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE and DONE only.
- stage_done  in  NUM_STAGES  per-stage done level flags.
- best_found_reg  in  DATA_WIDTH  current population best chromosome.
- best_found_fitness  in  FIT_WIDTH  fitness of best_found_reg.
- target_en  in  1  enable target-fitness termination.
- target_fitness  in  FIT_WIDTH  termination threshold (>=).
- progress_pipeline  out  1  one-cycle advance pulse to all stages.
- busy  out  1  high in RUN/EVAL.
- done  out  1  high in DONE.
- term_reason  out  2  0 none, 1 generation limit, 2 target hit, 3 stagnation.
- gen_count  out  $clog2(GENERATION_COUNT+1)  completed generations.
- best_chrom  out  DATA_WIDTH  best chromosome of the run.
- best_fit  out  FIT_WIDTH  fitness of best_chrom.

Behaviour:
- Reset (synchronous): state IDLE; every output 0; pulse_cnt, stag_cnt and best_valid cleared. rst mid-run aborts immediately; no pulse is issued in the reset cycle or the cycle after.
- IDLE: start=1 -> RUN; clears gen_count, term_reason, best_valid, stag_cnt and pulse_cnt in the same edge.
- RUN: if all stage_done are high and progress_pipeline is currently 0, assert progress_pipeline for the next cycle. The mandatory low cycle between pulses means stage_done held high yields a pulse every 2 cycles.
- On the pulse-asserting edge, pulse_cnt increments. When pulse_cnt == NUM_STAGES-1, pulse_cnt wraps to 0, gen_count increments and the next state is EVAL.
- EVAL (1 cycle; progress_pipeline is high during it) samples best_found_reg/best_found_fitness:
  - If !best_valid or best_found_fitness > best_fit: update best_chrom and best_fit, set best_valid, clear stag_cnt.
  - Otherwise stag_cnt++. Equal fitness counts as no improvement.
- Termination is evaluated in EVAL using the freshly sampled values. Priority:
  - target: target_en and best_found_fitness >= target_fitness -> reason 2.
  - limit: gen_count == GENERATION_COUNT -> reason 1.
  - stagnation: STAGNATION_LIMIT != 0 and the updated stag_cnt == STAGNATION_LIMIT -> reason 3.
  - If any condition fires, go to DONE; otherwise return to RUN. No pulse is issued in EVAL.
- DONE: done=1; busy=0; progress_pipeline=0. Outputs are held until start (-> RUN, counters cleared as above) or rst.
- start while busy is ignored. stage_done is ignored outside RUN.
- All comparisons are unsigned. gen_count never exceeds GENERATION_COUNT, and stag_cnt saturates at STAGNATION_LIMIT.

Decomposition:
- Package ga_ctrl_pkg holds the state enum (IDLE, RUN, EVAL, DONE) and the term_reason constants TERM_NONE, TERM_LIMIT, TERM_TARGET, TERM_STAG.
- One sub-module, ga_best_tracker: sample enable, compare, best register and stagnation counter with saturation; exposes best_chrom, best_fit and a stag_hit flag.

Test Plan:
- Basic run: rst, start, all stage_done held high, fitness constant 5, GENERATION_COUNT=16, STAGNATION_LIMIT=0 -> 64 pulses each 1 cycle wide with a low cycle between them; done with term_reason=1, gen_count=16, best_fit=5.
- Stall: drop stage_done[2] for 10 cycles mid-generation -> no pulse during the stall; pulses resume within 1 cycle of release; gen_count is unaffected.
- Target: target_en=1, target_fitness=100, fitness 10,20,...,100 per generation -> done after generation 10, term_reason=2, best_fit=100.
- Stagnation: STAGNATION_LIMIT=3, fitness 7 then 7,7,7 -> done at gen_count=4, term_reason=3, best_fit=7, best_chrom equals the generation-1 chromosome.
- Simultaneous: at gen 16, fitness >= target -> term_reason=2 (target beats limit).
- Reset and restart: rst during generation 5 -> all outputs 0 next cycle and no pulse; start after DONE -> gen_count=0, term_reason=0, fresh best tracking.
